score_keeper: RTL and testbench



---
 rtl/score_keeper.sv | 195 +++++++++++++++++++
 tb/tb_score_keeper.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_keeper: gameplay statistics (combo, base/bonus score) plus accuracy |
// | and grade from a 36-iteration restoring divider.          Revision 1.0    |
// +--------------------------------------------------------------------------+
module score_keeper #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         judge_valid,
  input  logic [1:0]   judge,
  input  logic [1:0]   mod,
  output logic [W-1:0] combo,
  output logic [W-1:0] base_score,
  output logic [W-1:0] bonus_score,
  output logic [W-1:0] acc,
  output logic [2:0]   level,
  output logic         busy
);
  localparam int NW = 36;
  localparam int DW = W + 2;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  combo_q, combo_d, base_q, base_d, bonus_q, bonus_d;
  logic [W-1:0]  acc_q, acc_d, judged_q, judged_d;
  logic [DW-1:0] wsum_q, wsum_d, den_q, den_d, rem_q, rem_d;
  logic [NW-1:0] num_q, num_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [2:0]    level_q, level_d;
  logic          busy_q, busy_d, pend_q, pend_d, ev_q, ev_d;

  logic [8:0]    w_points;
  logic [8:0]    w_inc_raw;
  logic [9:0]    w_inc;
  logic [W:0]    w_combo_sum, w_base_sum, w_bonus_sum, w_judged_sum;
  logic [DW:0]   w_wsum_sum;
  logic [W-1:0]  w_combo_new;
  logic [NW-1:0] w_num_in;
  logic [DW-1:0] w_rem_in, w_den_in, w_rem_next;
  logic [DW:0]   w_trial;
  logic          w_ge;
  logic [NW-1:0] w_num_next;
  logic [W-1:0]  w_quot;

  function automatic logic [2:0] grade(input logic [W-1:0] a);
    if (a >= W'(10000))     grade = 3'd5;
    else if (a >= W'(9500)) grade = 3'd4;
    else if (a >= W'(9000)) grade = 3'd3;
    else if (a >= W'(8000)) grade = 3'd2;
    else if (a >= W'(7000)) grade = 3'd1;
    else                    grade = 3'd0;
  endfunction

  always_comb begin
    case (judge)
      2'b11:   w_points = 9'd300;
      2'b10:   w_points = 9'd200;
      2'b01:   w_points = 9'd100;
      default: w_points = 9'd0;
    endcase

    w_combo_sum = {1'b0, combo_q} + (W+1)'(1);
    if (judge == 2'b00)     w_combo_new = '0;
    else if (w_combo_sum[W]) w_combo_new = '1;
    else                     w_combo_new = w_combo_sum[W-1:0];

    // Bonus tier follows the combo value after this event is counted
    if (w_combo_new >= W'(50))      w_inc_raw = w_points;
    else if (w_combo_new >= W'(10)) w_inc_raw = w_points >> 1;
    else                            w_inc_raw = '0;

    case (mod)
      2'b01:   w_inc = {w_inc_raw, 1'b0};
      2'b10:   w_inc = 10'(w_inc_raw >> 1);
      2'b11:   w_inc = '0;
      default: w_inc = {1'b0, w_inc_raw};
    endcase

    w_base_sum   = {1'b0, base_q} + (W+1)'(w_points);
    w_bonus_sum  = {1'b0, bonus_q} + (W+1)'(w_inc);
    w_judged_sum = {1'b0, judged_q} + (W+1)'(1);
    w_wsum_sum   = {1'b0, wsum_q} + (DW+1)'(judge);

    // The LOAD edge performs the first iteration on freshly latched operands
    w_rem_in   = (state_q == LOAD) ? '0 : rem_q;
    w_num_in   = (state_q == LOAD) ? NW'(wsum_q) * NW'(10000) : num_q;
    w_den_in   = (state_q == LOAD) ? DW'(judged_q) * DW'(3) : den_q;
    w_trial    = {w_rem_in, w_num_in[NW-1]};
    w_ge       = (w_trial >= {1'b0, w_den_in});
    w_rem_next = w_ge ? DW'(w_trial - {1'b0, w_den_in}) : w_trial[DW-1:0];
    w_num_next = {w_num_in[NW-2:0], w_ge};
    w_quot     = (num_q > NW'(10000)) ? W'(10000) : num_q[W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    combo_d  = combo_q;
    base_d   = base_q;
    bonus_d  = bonus_q;
    acc_d    = acc_q;
    level_d  = level_q;
    judged_d = judged_q;
    wsum_d   = wsum_q;
    den_d    = den_q;
    rem_d    = rem_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ev_d     = 1'b0;

    case (state_q)
      IDLE: if (ev_q || pend_q) state_d = LOAD;
      LOAD: begin
        den_d   = w_den_in;
        num_d   = w_num_next;
        rem_d   = w_rem_next;
        cnt_d   = 6'd1;
        pend_d  = 1'b0;
        state_d = DIV;
      end
      DIV: begin
        num_d = w_num_next;
        rem_d = w_rem_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(NW-1)) state_d = DONE;
      end
      DONE: begin
        acc_d   = w_quot;
        level_d = grade(w_quot);
        state_d = pend_q ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (judge_valid) begin
      combo_d  = w_combo_new;
      base_d   = w_base_sum[W]   ? '1 : w_base_sum[W-1:0];
      bonus_d  = w_bonus_sum[W]  ? '1 : w_bonus_sum[W-1:0];
      judged_d = w_judged_sum[W] ? '1 : w_judged_sum[W-1:0];
      wsum_d   = w_wsum_sum[DW]  ? '1 : w_wsum_sum[DW-1:0];
      ev_d     = 1'b1;
      if (state_q != IDLE) pend_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      state_q  <= IDLE;
      combo_q  <= '0;
      base_q   <= '0;
      bonus_q  <= '0;
      acc_q    <= '0;
      level_q  <= '0;
      judged_q <= '0;
      wsum_q   <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      ev_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      combo_q  <= combo_d;
      base_q   <= base_d;
      bonus_q  <= bonus_d;
      acc_q    <= acc_d;
      level_q  <= level_d;
      judged_q <= judged_d;
      wsum_q   <= wsum_d;
      den_q    <= den_d;
      rem_q    <= rem_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      ev_q     <= ev_d;
    end
  end

  assign combo       = combo_q;
  assign base_score  = base_q;
  assign bonus_score = bonus_q;
  assign acc         = acc_q;
  assign level       = level_q;
  assign busy        = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// tb_score_keeper: directed table-driven checks of score_keeper statistics,
// accuracy division timing, grade thresholds and pending reruns.
module tb_score_keeper;
  localparam int W = 21;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         judge_valid = 1'b0;
  logic [1:0]   judge = 2'b00;
  logic [1:0]   mod = 2'b00;
  logic [W-1:0] combo, base_score, bonus_score, acc;
  logic [2:0]   level;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       clr;
    logic       v;
    logic [1:0] j;
    logic [1:0] m;
    int         e_combo;
    int         e_base;
    int         e_bonus;
  } vec_t;

  typedef struct {
    int np;
    int ngr;
    int ngd;
    int e_acc;
    int e_lvl;
  } lvl_t;

  vec_t tbl[17];
  lvl_t lvl_tbl[6];

  score_keeper #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .judge_valid (judge_valid),
    .judge       (judge),
    .mod         (mod),
    .combo       (combo),
    .base_score  (base_score),
    .bonus_score (bonus_score),
    .acc         (acc),
    .level       (level),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [1:0] j, input logic [1:0] m);
    judge_valid = 1'b1;
    judge = j;
    mod = m;
    tick();
    judge_valid = 1'b0;
  endtask

  task automatic clear();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Idle means busy low on two consecutive cycles (rules out a DONE->IDLE->LOAD blip)
  task automatic wait_idle(input string name);
    int zeros = 0;
    for (int i = 0; i < 400 && zeros < 2; i++) begin
      tick();
      if (!busy) zeros++;
      else zeros = 0;
    end
    check({name, "_idle_reached"}, zeros, 2);
  endtask

  task automatic check_acc(input string name, input int e_acc, input int e_lvl);
    check({name, "_acc"}, longint'(acc), e_acc);
    check({name, "_level"}, longint'(level), e_lvl);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, fall, acc37, acc38;

    tbl[0] = '{1'b1, 1'b1, 2'd3, 2'd0, 0, 0, 0};
    for (int k = 1; k <= 9; k++) tbl[k] = '{1'b0, 1'b1, 2'd3, 2'd0, k, 300 * k, 0};
    tbl[10] = '{1'b0, 1'b1, 2'd3, 2'd3, 10, 3000, 0};
    tbl[11] = '{1'b0, 1'b1, 2'd3, 2'd0, 11, 3300, 150};
    tbl[12] = '{1'b0, 1'b1, 2'd3, 2'd1, 12, 3600, 450};
    tbl[13] = '{1'b0, 1'b1, 2'd3, 2'd2, 13, 3900, 525};
    tbl[14] = '{1'b0, 1'b1, 2'd0, 2'd0, 0, 3900, 525};
    tbl[15] = '{1'b0, 1'b1, 2'd1, 2'd1, 1, 4000, 525};
    tbl[16] = '{1'b0, 1'b0, 2'd3, 2'd0, 1, 4000, 525};

    lvl_tbl[0] = '{17, 3, 0, 9500, 4};
    lvl_tbl[1] = '{16, 4, 0, 9333, 3};
    lvl_tbl[2] = '{7, 3, 0, 9000, 3};
    lvl_tbl[3] = '{2, 3, 0, 8000, 2};
    lvl_tbl[4] = '{1, 9, 0, 7000, 1};
    lvl_tbl[5] = '{1, 0, 1, 6666, 0};

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_combo", longint'(combo), 0);
    check("rst_base", longint'(base_score), 0);
    check("rst_bonus", longint'(bonus_score), 0);
    check("rst_acc", longint'(acc), 0);
    check("rst_level", longint'(level), 0);
    check("rst_busy", longint'(busy), 0);

    // Three consecutive perfects
    for (int k = 0; k < 3; k++) ev(2'd3, 2'd0);
    check("p3_combo", longint'(combo), 3);
    check("p3_base", longint'(base_score), 900);
    check("p3_bonus", longint'(bonus_score), 0);
    check("p3_busy", longint'(busy), 1);
    wait_idle("p3");
    check_acc("p3", 10000, 5);

    // start mid-division aborts and clears
    ev(2'd1, 2'd0);
    repeat (10) tick();
    clear();
    check("abort_busy", longint'(busy), 0);
    check("abort_acc", longint'(acc), 0);
    check("abort_level", longint'(level), 0);
    check("abort_combo", longint'(combo), 0);
    check("abort_base", longint'(base_score), 0);
    repeat (50) tick();
    check("abort_hold_busy", longint'(busy), 0);
    check("abort_hold_acc", longint'(acc), 0);

    // Single great: divider latency and acc hold
    ev(2'd2, 2'd0);
    check("t1_busy_at_event", longint'(busy), 0);
    rise = -1; fall = -1; acc37 = -1; acc38 = -1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (busy && rise < 0) rise = k;
      if (!busy && rise >= 0 && fall < 0) fall = k;
      if (k == 37) acc37 = int'(acc);
      if (k == 38) acc38 = int'(acc);
    end
    check("t1_busy_rise", rise, 1);
    check("t1_busy_fall", fall, 38);
    check("t1_acc_held", acc37, 0);
    check("t1_acc_written", acc38, 6666);
    check("t1_level", longint'(level), 0);

    // perfect, miss, good
    clear();
    ev(2'd3, 2'd0);
    ev(2'd0, 2'd0);
    ev(2'd1, 2'd0);
    check("pmg_combo", longint'(combo), 1);
    check("pmg_base", longint'(base_score), 400);
    check("pmg_bonus", longint'(bonus_score), 0);
    wait_idle("pmg");
    check_acc("pmg", 4444, 0);

    // Vector table: start/event priority, bonus tiers and modifiers
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].clr;
      judge_valid = tbl[i].v;
      judge = tbl[i].j;
      mod = tbl[i].m;
      tick();
      start = 1'b0;
      judge_valid = 1'b0;
      check($sformatf("vec%0d_combo", i), longint'(combo), tbl[i].e_combo);
      check($sformatf("vec%0d_base", i), longint'(base_score), tbl[i].e_base);
      check($sformatf("vec%0d_bonus", i), longint'(bonus_score), tbl[i].e_bonus);
    end
    wait_idle("vec");
    check_acc("vec", 8888, 2);

    // 12 greats, bonus x2
    clear();
    for (int k = 1; k <= 12; k++) begin
      ev(2'd2, 2'd1);
      if (k == 9) check("g12_bonus_at9", longint'(bonus_score), 0);
      if (k == 10) check("g12_bonus_at10", longint'(bonus_score), 200);
    end
    check("g12_combo", longint'(combo), 12);
    check("g12_base", longint'(base_score), 2400);
    check("g12_bonus", longint'(bonus_score), 600);
    wait_idle("g12");
    check_acc("g12", 6666, 0);

    // 60 perfects, bonus /2
    clear();
    for (int k = 1; k <= 60; k++) ev(2'd3, 2'd2);
    check("p60_combo", longint'(combo), 60);
    check("p60_base", longint'(base_score), 18000);
    check("p60_bonus", longint'(bonus_score), 4650);
    wait_idle("p60");
    check_acc("p60", 10000, 5);

    // Grade thresholds
    for (int i = 0; i < 6; i++) begin
      clear();
      for (int k = 0; k < lvl_tbl[i].np; k++) ev(2'd3, 2'd0);
      for (int k = 0; k < lvl_tbl[i].ngr; k++) ev(2'd2, 2'd0);
      for (int k = 0; k < lvl_tbl[i].ngd; k++) ev(2'd1, 2'd0);
      wait_idle($sformatf("lvl%0d", i));
      check_acc($sformatf("lvl%0d", i), lvl_tbl[i].e_acc, lvl_tbl[i].e_lvl);
    end

    // Events every 10 cycles while busy: pending rerun, busy never drops
    clear();
    ev(2'd2, 2'd0);
    fall = -1; acc38 = -1;
    for (int k = 1; k <= 90; k++) begin
      if (k == 10 || k == 30) begin judge_valid = 1'b1; judge = 2'd3; end
      if (k == 20) begin judge_valid = 1'b1; judge = 2'd1; end
      tick();
      judge_valid = 1'b0;
      if (!busy && fall < 0) fall = k;
      if (k == 38) acc38 = int'(acc);
    end
    check("pend_first_acc", acc38, 6666);
    check("pend_busy_fall", fall, 75);
    check("pend_combo", longint'(combo), 4);
    check("pend_base", longint'(base_score), 900);
    check_acc("pend", 7500, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
